multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle RV32I-subset core: add, sub, and, or, srl, addi, ori, lw, sw, beq. It sequences every instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and mux selects, and it is the source of the ALUOp1/ALUOp0 pair consumed by the ALU control decoder. It sits between the instruction register opcode field and the datapath, and it stalls on a single-cycle-or-longer memory ready handshake.

## Interface
Parameters: none; opcodes and state codes come from the shared definitions file.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state to IDLE
- opcode  in  7  IR[6:0]; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite  out  1 each  datapath controls
- ALUSrcA  out  2  00 PC, 01 OldPC (latched with IRWrite), 10 rs1 register A
- ALUSrcB  out  2  00 rs2 register B, 01 constant 4, 10 immediate
- PCSource  out  1  0 ALU result, 1 ALUOut
- ALUOp1, ALUOp0  out  1 each  to ALU control: 00 add, 01 branch-sub, 10 R-type, 11 I-type
- illegal_op  out  1  unrecognised opcode; asserted during DECODE
- retire  out  1  one pulse in the last cycle of each instruction
- state  out  4  current state code, for debug and bench

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH.
- Outputs are Moore from state. Exceptions: IRWrite, PCWrite and retire are qualified by mem_ready where noted. Every output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0, IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 goes to EXEC_R
  - 0010011 goes to EXEC_I
  - 0000011 or 0100011 goes to MEM_ADDR
  - 1100011 goes to BRANCH
  - any other opcode sets illegal_op=1 and goes to FETCH, with no retire.
- MEM_ADDR: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for a load, MEM_WRITE for a store. The opcode is held by the IR.
- MEM_READ: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, retire=1. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, retire=mem_ready. Waits for mem_ready, then goes to FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALU_WB.
- EXEC_I: ALUSrcA=10, ALUSrcB=10, ALUOp=11. Goes to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, retire=1. Goes to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, retire=1. Goes to FETCH.
- PCWrite and PCWriteCond are never both 1. MemRead and MemWrite are never both 1.

## Timing
- Reset asserted: state=IDLE immediately, without waiting for a clock edge, and all outputs are 0. The first edge after deassertion moves the FSM to FETCH.
- Reset mid-instruction aborts the instruction. No RegWrite, MemWrite or PCWrite is issued after the reset edge.
- Cycles per instruction with mem_ready=1 every cycle:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - illegal opcode: 2
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Outputs hold steady while stalled.
- mem_ready is ignored in every other state.
- opcode changes outside DECODE and MEM_ADDR have no effect.

## Structure
- Shared definitions file control_defs.vh holds:
  - the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - the 4-bit state codes, IDLE=0 through BRANCH=10
  - the ALUSrcA, ALUSrcB and ALUOp encodings.
- One sub-module, control_outputs: a purely combinational decode from {state, mem_ready} to all outputs.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset mid-MEM_WRITE with mem_ready=0: outputs go to 0 asynchronously, state=0; after release, FETCH is reached in 1 cycle.
- add (0110011), mem_ready=1:
  - state sequence 1,2,7,9
  - ALUOp=10 in EXEC_R
  - RegWrite=1 only in ALU_WB
  - retire=1 once; 4 cycles total.
- lw with mem_ready low for 3 cycles in MEM_READ:
  - 8 cycles total
  - MemRead and IorD held at 1 throughout the stall
  - MemtoReg=RegWrite=1 for exactly 1 cycle.
- sw, mem_ready=1: ALUOp=00 in MEM_ADDR, MemWrite=1 for 1 cycle, no RegWrite.
- beq: 3 cycles; ALUOp=01 with PCWriteCond=1 and PCSource=1 in BRANCH; PCWrite=0 in BRANCH.
- opcode 1111111 in DECODE: illegal_op=1 for 1 cycle, back to FETCH next cycle, retire stays 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: opcodes,
// FSM state codes and the datapath mux / ALUOp encodings.
package multicycle_control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    function automatic logic op_known(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
    endfunction

endpackage

// File: rtl/multicycle_control_outputs.sv
// Moore decode of the FSM state into datapath controls; mem_ready only
// qualifies the fetch write-back and the store retire pulse.
module control_outputs
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       pc_source_o,
    output logic [1:0] alu_op_o,
    output logic       retire_o
);

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = SRCA_PC;
        alu_src_b_o     = SRCB_RS2;
        pc_source_o     = 1'b0;
        alu_op_o        = ALUOP_ADD;
        retire_o        = 1'b0;
        case (state_i)
            S_FETCH: begin
                // PC+4 and the IR load both land only when memory delivers
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target OldPC+imm parked in ALUOut
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                retire_o     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                retire_o    = mem_ready_i;
            end
            S_EXEC_R: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_RS2;
                alu_op_o    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ITYPE;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = SRCA_RS1;
                alu_src_b_o     = SRCB_RS2;
                alu_op_o        = ALUOP_BRANCH;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 1'b1;
                retire_o        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle core: state register, opcode-driven
// next-state logic, and the output decoder instance.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic       illegal_op,
    output logic       retire,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default:            state_d = S_FETCH;
                endcase
            end
            // IR still holds the instruction, so the opcode separates lw from sw
            S_MEM_ADDR:  state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I:           state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        state      = state_q;
        illegal_op = (state_q == S_DECODE) && !op_known(opcode);
        ALUOp1     = alu_op[1];
        ALUOp0     = alu_op[0];
    end

    control_outputs u_outputs (
        .state_i         (state_q),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (PCWrite),
        .pc_write_cond_o (PCWriteCond),
        .iord_o          (IorD),
        .mem_read_o      (MemRead),
        .mem_write_o     (MemWrite),
        .ir_write_o      (IRWrite),
        .mem_to_reg_o    (MemtoReg),
        .reg_write_o     (RegWrite),
        .alu_src_a_o     (ALUSrcA),
        .alu_src_b_o     (ALUSrcB),
        .pc_source_o     (PCSource),
        .alu_op_o        (alu_op),
        .retire_o        (retire)
    );

endmodule
